// File: rtl/spawn_slot_picker.sv
`default_nettype none
// ============================================================================
// spawn_slot_picker: freezes the LFSR, samples a candidate slot and scans the
// 4-slot occupancy map for the first free one, presented under valid/ack.
// Revision: 1.0
// ============================================================================
module spawn_slot_picker #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] random,
  input  logic [3:0] occupied,
  input  logic       slot_ack,
  output logic       stop,
  output logic       busy,
  output logic       slot_valid,
  output logic [1:0] slot,
  output logic       none_free
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_SCAN    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_hold_cnt;
  logic [1:0] r_cand;
  logic [1:0] r_tries;
  logic [1:0] r_slot;
  logic       r_none_free;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= 4'd0;
      r_cand      <= 2'd0;
      r_tries     <= 2'd0;
      r_slot      <= 2'd0;
      r_none_free <= 1'b0;
    end else begin
      r_none_free <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_hold_cnt <= 4'd0;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt + 4'd1;
          // random is only meaningful while stop is high, i.e. in this state
          if (r_hold_cnt == C_HOLD_LAST) begin
            r_cand  <= random;
            r_tries <= 2'd0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!occupied[r_cand]) begin
            r_slot  <= r_cand;
            r_state <= S_PRESENT;
          end else if (r_tries == 2'd3) begin
            r_none_free <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cand  <= r_cand + 2'd1;
            r_tries <= r_tries + 2'd1;
          end
        end
        S_PRESENT: begin
          if (slot_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stop       = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign slot_valid = (r_state == S_PRESENT);
  assign slot       = r_slot;
  assign none_free  = r_none_free;

endmodule
`default_nettype wire

// File: doc/spawn_slot_picker.md
# spawn_slot_picker

Downstream consumer of the 2-bit LFSR random source in the VGA game path. On a spawn request it freezes the LFSR via `stop`, samples the 2-bit value as a candidate slot, then scans the 4-slot occupancy map (wrapping) for the first free slot. The chosen slot is presented to the drawing/game logic under a valid/ack handshake; if no slot is free, the block reports that condition instead.

## Interface
- `HOLD_CYCLES`, default 2: cycles `stop` is held high before sampling `random`; legal range 1..15.
- `clk  in  1`: system clock. All logic is rising-edge.
- `rst  in  1`: synchronous reset, active-low. Sampled only on the `clk` edge; `rst`=0 resets all state.
- `req  in  1`: spawn request. Sampled only in IDLE.
- `random  in  2`: LFSR output. Valid only while `stop`=1; the source drives 0 otherwise.
- `occupied  in  4`: bit i=1 means slot i is taken. Read live during SCAN.
- `slot_ack  in  1`: consumer accepts the presented slot.
- `stop  out  1`: freeze/sample request to the LFSR.
- `busy  out  1`: high in every state except IDLE.
- `slot_valid  out  1`: `slot` holds a valid free slot.
- `slot  out  2`: chosen slot index.
- `none_free  out  1`: one-cycle pulse; all 4 slots were occupied.

## Operation
- Registered Moore FSM with states IDLE, HOLD, SCAN and PRESENT. All outputs decode from registered state and registers.
- IDLE: `stop`=0, `busy`=0, `slot_valid`=0. If `req`=1, go to HOLD and clear the hold counter.
- HOLD: `stop`=1. The counter increments each cycle.
  - In the cycle where counter = `HOLD_CYCLES`-1: latch `cand` <= `random`, clear `tries`, and go to SCAN.
- SCAN: `stop`=0. One slot is examined per cycle.
  - If `occupied[cand]`=0: latch `slot` <= `cand` and go to PRESENT.
  - Otherwise, if `tries`=3: set `none_free` for the next cycle and go to IDLE.
  - Otherwise: `cand` <= `cand`+1 mod 4 (3 wraps to 0), and `tries` increments.
- PRESENT: `slot_valid`=1 and `slot` is held stable. On `slot_ack`=1, go to IDLE. No timeout.
- `req` is ignored outside IDLE. It is not queued. If `req` and `slot_ack` are both high in PRESENT, the ack is taken and the `req` is dropped.
- `slot_ack` outside PRESENT is ignored.
- `occupied` changing during SCAN: each cycle uses the current value. Slots already passed are not revisited.
- Reset values: state IDLE; `stop`, `busy`, `slot_valid` and `none_free` = 0; `slot`, `cand`, `tries` and the hold counter = 0.
- Reset in any state, including HOLD with `stop` high, returns to IDLE at that edge. `stop` is low in the next cycle.
- Widths: `cand` and `tries` are 2 bits, using natural modulo-4 wrap. The hold counter is 4 bits.

## Timing
- `req` sampled high at edge k:
  - `stop`=1 during cycles k+1 .. k+`HOLD_CYCLES`.
  - `cand` is latched at edge k+`HOLD_CYCLES`.
- With j occupied slots skipped before the first free one (j = 0..3):
  - `slot_valid` rises after edge k+`HOLD_CYCLES`+1+j.
  - Best-case latency with default parameters is 3 cycles; worst case is 6.
- All slots full:
  - `none_free`=1 for exactly the one cycle after edge k+`HOLD_CYCLES`+4, while the state is IDLE.
  - A `req` in that cycle is accepted normally.
- Handshake completes at the edge where `slot_valid`=`slot_ack`=1. `slot_valid` is low in the next cycle. The earliest next `req` acceptance is that same following cycle.

## Test plan
- Reset with `rst`=0 for 2 cycles, then `req` pulse. `stop`=1 for exactly 2 cycles, `busy`=1 from k+1, and all outputs were 0 during reset.
- `occupied`=4'b0000, `random`=2'b10 while `stop` is high. `slot_valid` rises after edge k+3 with `slot`=2. It stays stable for 5 cycles without ack, then drops one cycle after `slot_ack`.
- `occupied`=4'b1000, `random`=2'b11 (wrap case). Scan goes 3 (occupied) then 0 (free). `slot`=0 and `slot_valid` rises after edge k+4.
- `occupied`=4'b1111, any `random`. No `slot_valid`; `none_free` is a single pulse in the cycle after edge k+6; `busy` returns to 0 then.
- `rst` asserted low during HOLD. `stop` and `busy` are 0 in the next cycle, and a fresh `req` afterwards yields the normal 3-cycle latency.
- `req` held high throughout PRESENT, with `slot_ack` and `req` high in the same cycle. Only one slot is presented before IDLE. The still-high `req` is accepted in IDLE as a new request with `HOLD_CYCLES`=2 timing.
